// File: rtl/sogi_pll_pkg.sv
// Shared SOGI-PLL constants (Q8.24) and the phase-integrator state encoding.
// The PI controller and the sin/cos stage use the same definitions.
package sogi_pll_pkg;

   localparam int DATA_WIDTH_DEF   = 32;
   localparam int FP_WIDTH_DEF     = 24;
   localparam int PERIOD_WIDTH_DEF = 16;

   localparam logic [31:0] TWO_PI_Q824   = 32'd105414357;
   localparam logic [31:0] DPHI_NOM_60HZ = 32'd126496;
   localparam logic [31:0] DPHI_NOM_50HZ = 32'd105414;
   localparam logic [31:0] DPHI_MAX_DEF  = 32'd252992;
   localparam logic [31:0] TS_Q_50KHZ    = 32'd85899;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MULT,
      ST_SCALE,
      ST_ACC,
      ST_WRAP,
      ST_OUT
   } pll_state_e;

endpackage

// File: rtl/pll_phase_integrator_if.sv
// Handshake bundle between the PI stage, the phase integrator and its consumers.
interface pll_phase_integrator_if
   import sogi_pll_pkg::*;
#(
   parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int PERIOD_WIDTH = PERIOD_WIDTH_DEF
);

   logic signed [DATA_WIDTH-1:0] omega_corr;
   logic                         in_data_valid;
   logic                         in_data_ready;
   logic [DATA_WIDTH-1:0]        theta;
   logic [DATA_WIDTH-1:0]        dphi;
   logic [PERIOD_WIDTH-1:0]      period_count;
   logic                         wrap;
   logic                         sat;
   logic                         out_data_valid;
   logic                         out_data_ready;

   modport master (
      output omega_corr, in_data_valid, out_data_ready,
      input  in_data_ready, theta, dphi, period_count, wrap, sat, out_data_valid
   );

   modport slave (
      input  omega_corr, in_data_valid, out_data_ready,
      output in_data_ready, theta, dphi, period_count, wrap, sat, out_data_valid
   );

endinterface

// File: rtl/pll_phase_integrator_phase_wrap_acc.sv
// Phase accumulate and wrap into [0, 2pi), plus the samples-per-cycle counter
// whose value is captured into period_count on every wrap.
module phase_wrap_acc
   import sogi_pll_pkg::*;
#(
   parameter int                    DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int                    PERIOD_WIDTH = PERIOD_WIDTH_DEF,
   parameter logic [DATA_WIDTH-1:0] TWO_PI       = DATA_WIDTH'(TWO_PI_Q824)
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    acc_en,
   input  logic                    wrap_en,
   input  logic [DATA_WIDTH-1:0]   theta,
   input  logic [DATA_WIDTH-1:0]   dphi,
   output logic [DATA_WIDTH-1:0]   theta_next,
   output logic                    wrap_next,
   output logic [PERIOD_WIDTH-1:0] period_count
);

   logic [DATA_WIDTH:0]     sum_q, sum_d;
   logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
   logic [PERIOD_WIDTH-1:0] period_q, period_d;
   logic [DATA_WIDTH-1:0]   sum_wrapped;

   always_comb begin
      sum_d    = sum_q;
      cnt_d    = cnt_q;
      period_d = period_q;

      if (acc_en) begin
         sum_d = {1'b0, theta} + {1'b0, dphi};
      end

      // One subtraction suffices since dphi never exceeds 2pi; the true result fits DATA_WIDTH.
      wrap_next   = (sum_q >= {1'b0, TWO_PI});
      sum_wrapped = sum_q[DATA_WIDTH-1:0] - TWO_PI;
      theta_next  = wrap_next ? sum_wrapped : sum_q[DATA_WIDTH-1:0];

      if (wrap_en) begin
         if (wrap_next) begin
            period_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
            cnt_d    = '0;
         end else if (!(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         sum_q    <= '0;
         cnt_q    <= '0;
         period_q <= '0;
      end else begin
         sum_q    <= sum_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
      end
   end

   assign period_count = period_q;

endmodule

// File: rtl/pll_phase_integrator.sv
// SOGI-PLL phase integrator: scales the PI frequency correction to a per-sample
// phase step, clamps it, and integrates it into a wrapped phase angle.
module pll_phase_integrator
   import sogi_pll_pkg::*;
#(
   parameter int                    DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int                    FP_WIDTH     = FP_WIDTH_DEF,
   parameter logic [DATA_WIDTH-1:0] TWO_PI       = DATA_WIDTH'(TWO_PI_Q824),
   parameter logic [DATA_WIDTH-1:0] DPHI_NOM     = DATA_WIDTH'(DPHI_NOM_60HZ),
   parameter logic [DATA_WIDTH-1:0] DPHI_MAX     = DATA_WIDTH'(DPHI_MAX_DEF),
   parameter logic [DATA_WIDTH-1:0] TS_Q         = DATA_WIDTH'(TS_Q_50KHZ),
   parameter int                    PERIOD_WIDTH = PERIOD_WIDTH_DEF
) (
   input logic                   Clk,
   input logic                   Reset,
   pll_phase_integrator_if.slave bus
);

   localparam int PW = 2 * DATA_WIDTH;

   if (DPHI_MAX >= TWO_PI || FP_WIDTH >= DATA_WIDTH) begin : g_param_check
      $error("pll_phase_integrator: DPHI_MAX must be below TWO_PI and FP_WIDTH below DATA_WIDTH");
   end

   pll_state_e state_q, state_d;

   logic signed [DATA_WIDTH-1:0] omega_q, omega_d;
   logic signed [DATA_WIDTH-1:0] prod_hi_q, prod_hi_d;
   logic [DATA_WIDTH-1:0]        dphi_n_q, dphi_n_d;
   logic                         sat_n_q, sat_n_d;
   logic [DATA_WIDTH-1:0]        theta_q, theta_d;
   logic [DATA_WIDTH-1:0]        dphi_q, dphi_d;
   logic                         wrap_q, wrap_d;
   logic                         sat_q, sat_d;
   logic                         valid_q, valid_d;
   logic                         ready_q, ready_d;

   logic signed [DATA_WIDTH:0]   raw;
   logic [DATA_WIDTH-1:0]        clamp_val;
   logic                         clamp_sat;
   logic                         acc_en, wrap_en;
   logic [DATA_WIDTH-1:0]        theta_nx;
   logic                         wrap_nx;

   // Only the upper word of the 64-bit product is kept: it is exactly prod >>> 32 (floor).
   always_comb begin
      raw = $signed({1'b0, DPHI_NOM}) + $signed({prod_hi_q[DATA_WIDTH-1], prod_hi_q});
      clamp_val = raw[DATA_WIDTH-1:0];
      clamp_sat = 1'b0;
      if (raw[DATA_WIDTH]) begin
         clamp_val = '0;
         clamp_sat = 1'b1;
      end else if (raw > $signed({1'b0, DPHI_MAX})) begin
         clamp_val = DPHI_MAX;
         clamp_sat = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      omega_d   = omega_q;
      prod_hi_d = prod_hi_q;
      dphi_n_d  = dphi_n_q;
      sat_n_d   = sat_n_q;
      theta_d   = theta_q;
      dphi_d    = dphi_q;
      wrap_d    = wrap_q;
      sat_d     = sat_q;
      valid_d   = valid_q;
      ready_d   = 1'b0;
      acc_en    = 1'b0;
      wrap_en   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            ready_d = 1'b1;
            if (bus.in_data_valid && ready_q) begin
               omega_d = bus.omega_corr;
               ready_d = 1'b0;
               state_d = ST_MULT;
            end
         end
         ST_MULT: begin
            prod_hi_d = DATA_WIDTH'(($signed({{DATA_WIDTH{omega_q[DATA_WIDTH-1]}}, omega_q})
                                    * $signed({{DATA_WIDTH{1'b0}}, TS_Q})) >>> DATA_WIDTH);
            state_d   = ST_SCALE;
         end
         ST_SCALE: begin
            dphi_n_d = clamp_val;
            sat_n_d  = clamp_sat;
            state_d  = ST_ACC;
         end
         ST_ACC: begin
            acc_en  = 1'b1;
            state_d = ST_WRAP;
         end
         ST_WRAP: begin
            wrap_en = 1'b1;
            theta_d = theta_nx;
            dphi_d  = dphi_n_q;
            wrap_d  = wrap_nx;
            sat_d   = sat_n_q;
            valid_d = 1'b1;
            state_d = ST_OUT;
         end
         ST_OUT: begin
            if (bus.out_data_ready) begin
               valid_d = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= ST_IDLE;
         omega_q   <= '0;
         prod_hi_q <= '0;
         dphi_n_q  <= '0;
         sat_n_q   <= 1'b0;
         theta_q   <= '0;
         dphi_q    <= '0;
         wrap_q    <= 1'b0;
         sat_q     <= 1'b0;
         valid_q   <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         omega_q   <= omega_d;
         prod_hi_q <= prod_hi_d;
         dphi_n_q  <= dphi_n_d;
         sat_n_q   <= sat_n_d;
         theta_q   <= theta_d;
         dphi_q    <= dphi_d;
         wrap_q    <= wrap_d;
         sat_q     <= sat_d;
         valid_q   <= valid_d;
         ready_q   <= ready_d;
      end
   end

   phase_wrap_acc #(
      .DATA_WIDTH   (DATA_WIDTH),
      .PERIOD_WIDTH (PERIOD_WIDTH),
      .TWO_PI       (TWO_PI)
   ) u_wrap_acc (
      .Clk          (Clk),
      .Reset        (Reset),
      .acc_en       (acc_en),
      .wrap_en      (wrap_en),
      .theta        (theta_q),
      .dphi         (dphi_n_q),
      .theta_next   (theta_nx),
      .wrap_next    (wrap_nx),
      .period_count (bus.period_count)
   );

   assign bus.in_data_ready  = ready_q;
   assign bus.theta          = theta_q;
   assign bus.dphi           = dphi_q;
   assign bus.wrap           = wrap_q;
   assign bus.sat            = sat_q;
   assign bus.out_data_valid = valid_q;

endmodule

// File: tb/tb_pll_phase_integrator.sv
// Bench for pll_phase_integrator: default instance plus DPHI_MAX / DPHI_NOM overrides,
// all driven in lockstep; results of the default instance go through a scoreboard.
module tb_pll_phase_integrator;
   import sogi_pll_pkg::*;

   typedef struct {
      logic [31:0] omega;
      logic [31:0] theta;
      logic [31:0] dphi;
      logic [15:0] period;
      logic        wrap;
      logic        sat;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] omega = '0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;

   int   checks = 0;
   int   failures = 0;
   vec_t sb[$];
   vec_t mon_e;
   vec_t tbl[7];

   always #5 clk = ~clk;

   pll_phase_integrator_if #(.DATA_WIDTH(32), .PERIOD_WIDTH(16)) bus0 ();
   pll_phase_integrator_if #(.DATA_WIDTH(32), .PERIOD_WIDTH(16)) bus1 ();
   pll_phase_integrator_if #(.DATA_WIDTH(32), .PERIOD_WIDTH(16)) bus2 ();

   assign bus0.omega_corr = omega;
   assign bus0.in_data_valid = in_valid;
   assign bus0.out_data_ready = out_ready;
   assign bus1.omega_corr = omega;
   assign bus1.in_data_valid = in_valid;
   assign bus1.out_data_ready = out_ready;
   assign bus2.omega_corr = omega;
   assign bus2.in_data_valid = in_valid;
   assign bus2.out_data_ready = out_ready;

   pll_phase_integrator dut0 (.Clk(clk), .Reset(rst), .bus(bus0));
   pll_phase_integrator #(.DPHI_MAX(32'd126600)) dut1 (.Clk(clk), .Reset(rst), .bus(bus1));
   pll_phase_integrator #(.DPHI_NOM(32'd0)) dut2 (.Clk(clk), .Reset(rst), .bus(bus2));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && bus0.out_data_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_output", 32'(bus0.out_data_valid), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("theta", bus0.theta, mon_e.theta);
            check("dphi", bus0.dphi, mon_e.dphi);
            check("period_count", 32'(bus0.period_count), 32'(mon_e.period));
            check("wrap", 32'(bus0.wrap), 32'(mon_e.wrap));
            check("sat", 32'(bus0.sat), 32'(mon_e.sat));
         end
      end
   end

   task automatic wait_ready();
      int unsigned n = 0;
      while (bus0.in_data_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) check("ready_timeout", 32'(bus0.in_data_ready), 32'd1);
   endtask

   task automatic wait_out_valid(output int unsigned lat);
      lat = 1;
      while (bus0.out_data_valid !== 1'b1 && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic send(input vec_t v);
      int unsigned lat;
      omega = v.omega;
      in_valid = 1'b1;
      wait_ready();
      sb.push_back(v);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_out_valid(lat);
      check("latency", lat, 32'd5);
      @(posedge clk);
      #1;
      check("sb_drain", sb.size(), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_theta"}, bus0.theta, 32'd0);
      check({tag, "_dphi"}, bus0.dphi, 32'd0);
      check({tag, "_period"}, 32'(bus0.period_count), 32'd0);
      check({tag, "_wrap"}, 32'(bus0.wrap), 32'd0);
      check({tag, "_sat"}, 32'(bus0.sat), 32'd0);
      check({tag, "_valid"}, 32'(bus0.out_data_valid), 32'd0);
      check({tag, "_ready"}, 32'(bus0.in_data_ready), 32'd0);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned lat;
      longint      acc;
      vec_t        v;

      //            omega          theta        dphi         period wrap  sat
      tbl[0] = '{32'h00000000, 32'd126496, 32'd126496, 16'd0, 1'b0, 1'b0};
      tbl[1] = '{32'h01000000, 32'd253327, 32'd126831, 16'd0, 1'b0, 1'b0};
      tbl[2] = '{32'hFF000000, 32'd379487, 32'd126160, 16'd0, 1'b0, 1'b0};
      tbl[3] = '{32'h7FFFFFFF, 32'd548932, 32'd169445, 16'd0, 1'b0, 1'b0};
      tbl[4] = '{32'h80000000, 32'd632478, 32'd83546,  16'd0, 1'b0, 1'b0};
      tbl[5] = '{32'hFFFFFFFF, 32'd758973, 32'd126495, 16'd0, 1'b0, 1'b0};
      tbl[6] = '{32'h00000001, 32'd885469, 32'd126496, 16'd0, 1'b0, 1'b0};

      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("ready_after_reset", 32'(bus0.in_data_ready), 32'd1);

      for (int i = 0; i < 7; i++) send(tbl[i]);

      // Parameter overrides run in lockstep with the default instance.
      do_reset();
      send('{32'h01000000, 32'd126831, 32'd126831, 16'd0, 1'b0, 1'b0});
      check("max_dphi", bus1.dphi, 32'd126600);
      check("max_sat", 32'(bus1.sat), 32'd1);
      check("max_theta", bus1.theta, 32'd126600);
      check("nom0_dphi", bus2.dphi, 32'd335);
      check("nom0_sat", 32'(bus2.sat), 32'd0);
      check("nom0_theta", bus2.theta, 32'd335);
      send('{32'hFF000000, 32'd252991, 32'd126160, 16'd0, 1'b0, 1'b0});
      check("max_dphi2", bus1.dphi, 32'd126160);
      check("max_sat2", 32'(bus1.sat), 32'd0);
      check("max_theta2", bus1.theta, 32'd252760);
      check("nom0_dphi2", bus2.dphi, 32'd0);
      check("nom0_sat2", 32'(bus2.sat), 32'd1);
      check("nom0_theta2", bus2.theta, 32'd335);

      // Reset pulse while the FSM sits in WRAP aborts the sample.
      omega = 32'h0;
      in_valid = 1'b1;
      wait_ready();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_all_zero("wrap_reset");
      @(posedge clk);
      #1;
      check("wrap_reset_idle", 32'(bus0.in_data_ready), 32'd1);
      send('{32'h00000000, 32'd126496, 32'd126496, 16'd0, 1'b0, 1'b0});

      // Backpressure with a pending upstream sample.
      out_ready = 1'b0;
      omega = 32'h0;
      in_valid = 1'b1;
      wait_ready();
      sb.push_back('{32'h00000000, 32'd252992, 32'd126496, 16'd0, 1'b0, 1'b0});
      @(posedge clk);
      #1;
      wait_out_valid(lat);
      check("bp_latency", lat, 32'd5);
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         check("bp_theta", bus0.theta, 32'd252992);
         check("bp_dphi", bus0.dphi, 32'd126496);
         check("bp_valid", 32'(bus0.out_data_valid), 32'd1);
         check("bp_in_ready", 32'(bus0.in_data_ready), 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_valid_drop", 32'(bus0.out_data_valid), 32'd0);
      check("bp_ready_low", 32'(bus0.in_data_ready), 32'd0);
      @(posedge clk);
      #1;
      check("bp_ready_idle", 32'(bus0.in_data_ready), 32'd1);
      check("bp_sb_drain", sb.size(), 32'd0);
      repeat (12) @(posedge clk);
      #1;
      check("bp_no_extra", 32'(bus0.out_data_valid), 32'd0);

      // Full cycle at nominal frequency: first wrap on sample 834.
      do_reset();
      for (int k = 1; k <= 836; k++) begin
         acc = longint'(k) * 126496;
         v.omega = 32'h0;
         v.theta = 32'(acc % 105414357);
         v.dphi = 32'd126496;
         v.wrap = ((acc / 105414357) != ((acc - 126496) / 105414357));
         v.period = (k >= 834) ? 16'd834 : 16'd0;
         v.sat = 1'b0;
         send(v);
         if (k == 834) begin
            check("wrap834_theta", bus0.theta, 32'd83307);
            check("wrap834_flag", 32'(bus0.wrap), 32'd1);
            check("wrap834_period", 32'(bus0.period_count), 32'd834);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pll_phase_integrator.md
Name: pll_phase_integrator

Overview:
- Downstream stage of the SOGI-PLL PI controller.
- Takes the PI output (angular-frequency correction, Q8.24 rad/s) once per control sample and adds the nominal per-sample phase step.
- Integrates the result into the phase angle theta, wrapped to [0, 2pi).
- Publishes theta, the per-sample phase step and a samples-per-cycle period count over a valid/ready handshake to the sin/cos and Park stages.

Parameters:
- DATA_WIDTH, 32: width of all data words (signed Q8.24 unless noted).
- FP_WIDTH, 24: fractional bits.
- TWO_PI, 105414357: 2pi in Q8.24.
- DPHI_NOM, 126496: nominal phase step per sample, 2pi*60/50e3 in Q8.24.
- DPHI_MAX, 252992: upper clamp of the phase step, Q8.24. Must be < TWO_PI.
- TS_Q, 85899: sample period 1/50e3 as unsigned Q0.32.
- PERIOD_WIDTH, 16: width of the period counter.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- omega_corr  in  DATA_WIDTH  signed Q8.24 rad/s correction from the PI stage.
- in_data_valid  in  1  omega_corr valid.
- in_data_ready  out  1  block can accept a sample.
- theta  out  DATA_WIDTH  phase in Q8.24, range [0, TWO_PI).
- dphi  out  DATA_WIDTH  applied (clamped) phase step, Q8.24.
- period_count  out  PERIOD_WIDTH  samples in the last completed cycle.
- wrap  out  1  this result wrapped past 2pi.
- sat  out  1  phase step was clamped.
- out_data_valid  out  1  outputs valid.
- out_data_ready  in  1  consumer accepts.

Behaviour:
- Single clock, Clk. Reset is synchronous and active-high. All state is cleared on any Clk edge where Reset=1, including mid-operation; the next state is IDLE.
- Reset values:
  - theta, dphi, period_count = 0.
  - wrap, sat, out_data_valid, in_data_ready = 0.
  - Internal sample counter = 0.
- FSM states: IDLE, MULT, SCALE, ACC, WRAP, OUT.
- IDLE:
  - in_data_ready=1 (registered; it goes to 1 the cycle after entering IDLE).
  - When in_data_valid & in_data_ready: capture omega_corr, drop in_data_ready, go to MULT.
- MULT: prod = omega_corr * signed(TS_Q), 64-bit signed; TS_Q is zero-extended to 33 bits before the multiply.
- SCALE:
  - raw = DPHI_NOM + (prod >>> 32). The shift is arithmetic, so it floors toward -inf.
  - Clamp raw to [0, DPHI_MAX] into dphi_next. sat_next=1 if clamped.
- ACC: sum = theta + dphi_next, computed in DATA_WIDTH+1 bits. Cannot overflow because both operands are < TWO_PI < 2^30.
- WRAP:
  - If sum >= TWO_PI: theta_next = sum - TWO_PI, wrap_next=1, period_count <= sample counter + 1, sample counter <= 0.
  - Otherwise: theta_next = sum, wrap_next=0, sample counter increments, saturating at all-ones.
  - A single subtraction always suffices because DPHI_MAX < TWO_PI. Negative sums are impossible since dphi >= 0.
- OUT:
  - theta, dphi, wrap and sat are updated on the WRAP->OUT transition; out_data_valid=1.
  - Outputs stay stable while out_data_valid=1 and out_data_ready=0.
  - On out_data_ready=1: out_data_valid drops next cycle; return to IDLE.
- Latency: capture edge to out_data_valid = 5 cycles. Throughput is one sample per 6+ cycles; the 50 kHz sample rate is far below this.
- period_count holds its value between wraps. It reads 0 until the first wrap after reset.
- in_data_valid while busy is ignored (not queued); the upstream PI stage holds valid until ready.

Decomposition:
- Shared package sogi_pll_pkg holds:
  - Q8.24 constants TWO_PI and DPHI_NOM_60HZ/50HZ.
  - FP_WIDTH and DATA_WIDTH defaults.
  - FSM state encodings.
- These constants are shared with pi_controller and the sin/cos stage.
- One natural sub-module: phase_wrap_acc, covering ACC+WRAP, the sample counter and period capture. The FSM and multiplier stay in the top.

Test Plan:
- Reset, then omega_corr=0 for one sample: theta=126496, dphi=126496, wrap=0, sat=0, latency exactly 5 cycles from capture.
- omega_corr=16777216 (+1.0): dphi=126831. omega_corr=-16777216: dphi=126160, because the arithmetic shift floors -335.54 to -336.
- 834 samples at omega_corr=0 from reset: wrap=1 only on sample 834, theta=83307, period_count=834. Samples 835 onward have wrap=0 and period_count holds 834.
- Override DPHI_MAX=126600, omega_corr=16777216: dphi=126600, sat=1. Override DPHI_NOM=0, omega_corr=-16777216: dphi=0, sat=1, theta unchanged.
- Hold out_data_ready=0 for 10 cycles in OUT with in_data_valid=1: outputs stable, in_data_ready=0, no new capture. Release ready: one handshake, then IDLE.
- Assert Reset for one cycle while in WRAP: next cycle all outputs are 0 and the state is IDLE. The next sample yields theta=126496.
